lif_neuron_scheduler: RTL and testbench

Time-multiplexed controller that evaluates NUM_NEURONS virtual leaky-integrate-and-fire neurons through one shared combinational update unit. Each timestep it visits the neurons in index order and fetches each one's 8 synaptic spike bits and weights over a request/valid handshake. It then updates that neuron's stored membrane potential and refractory counter and emits output spike events over a valid/ready handshake. It sits between the synapse/weight memory (upstream) and the spike router (downstream) in the SNN array.

---
 rtl/lif_sched_pkg.sv | 29 ++
 rtl/lif_update_unit.sv | 53 +++++
 rtl/lif_neuron_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_lif_neuron_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_sched_pkg.sv
// -----------------------------------------------------------------------------
// lif_sched_pkg
// Shared types and widths for the time-multiplexed LIF neuron scheduler.
//   POT_W  : membrane potential width
//   REF_W  : refractory counter width
//   SYN_N  : synapses (spike bits / weights) per neuron
//   SUM_W  : width of the un-saturated synaptic sum
//   lif_state_e : scheduler FSM states
// -----------------------------------------------------------------------------
package lif_sched_pkg;

   localparam int POT_W = 8;
   localparam int REF_W = 4;
   localparam int SYN_N = 8;

   // The eight weights alone fit in 11 bits (max 2040), but adding a stored
   // potential of up to 255 reaches 2295. One extra bit keeps that sum from
   // wrapping so saturation to 255 is always correct.
   localparam int SUM_W = 12;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      UPDATE = 3'd2,
      EMIT   = 3'd3,
      DONE   = 3'd4
   } lif_state_e;

endpackage

// File: rtl/lif_update_unit.sv
// -----------------------------------------------------------------------------
// lif_update_unit
// Purely combinational leaky-integrate-and-fire update for one neuron.
// Inputs : potential, refrac (current neuron state), spike_in, weight
//          (synaptic data), threshold, leak_value, tref (step config).
// Outputs: potential_next, refrac_next (state to write back), fire.
// -----------------------------------------------------------------------------
module lif_update_unit
   import lif_sched_pkg::*;
(
   input  logic [POT_W-1:0]       potential,
   input  logic [REF_W-1:0]       refrac,
   input  logic [SYN_N-1:0]       spike_in,
   input  logic [SYN_N*POT_W-1:0] weight,
   input  logic [POT_W-1:0]       threshold,
   input  logic [POT_W-1:0]       leak_value,
   input  logic [REF_W-1:0]       tref,
   output logic [POT_W-1:0]       potential_next,
   output logic [REF_W-1:0]       refrac_next,
   output logic                   fire
);

   logic [SUM_W-1:0] sum_full;
   logic [POT_W-1:0] sum_sat;
   logic [POT_W-1:0] over_leak;

   always_comb begin
      sum_full = SUM_W'(potential);
      for (int k = 0; k < SYN_N; k++) begin
         if (spike_in[k]) begin
            sum_full = sum_full + SUM_W'(weight[POT_W*k +: POT_W]);
         end
      end
      // Any bit above the potential width means the sum exceeded 255.
      sum_sat   = (|sum_full[SUM_W-1:POT_W]) ? {POT_W{1'b1}} : sum_full[POT_W-1:0];
      over_leak = sum_sat - leak_value;

      potential_next = '0;
      refrac_next    = refrac;
      fire           = 1'b0;
      if (refrac != '0) begin
         refrac_next = refrac - 1'b1;
      end else if (sum_sat >= leak_value) begin
         if (over_leak >= threshold) begin
            refrac_next = tref;
            fire        = 1'b1;
         end else begin
            potential_next = over_leak;
         end
      end
   end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// lif_neuron_scheduler
// Evaluates NUM_NEURONS virtual LIF neurons per timestep through a single
// shared lif_update_unit, visiting neurons in index order.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   step_start                    pulse to begin a timestep (ignored when busy)
//   threshold, leak_value, tref   step config, captured on accepted step_start
//   syn_req, syn_idx              request synaptic data for neuron syn_idx
//   syn_valid, spike_in, weight   synaptic data response
//   out_valid, out_idx, out_ready spike event output
//   busy, step_done               step in progress / one-cycle completion pulse
//   dbg_idx, dbg_potential,
//   dbg_refrac                    combinational read of one neuron's state
//   dbg_state                     current FSM state
//
// Handshakes: the synapse fetch completes in the cycle where syn_req and
// syn_valid are both high; syn_req/syn_idx stay constant until then and
// syn_valid is ignored while syn_req is low. An output event transfers in the
// cycle where out_valid and out_ready are both high; out_valid/out_idx stay
// constant until then and never depend combinationally on out_ready.
// -----------------------------------------------------------------------------
module lif_neuron_scheduler
   import lif_sched_pkg::*;
#(
   parameter int NUM_NEURONS = 16,
   parameter int IDX_W       = $clog2(NUM_NEURONS)
)
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   step_start,
   input  logic [POT_W-1:0]       threshold,
   input  logic [POT_W-1:0]       leak_value,
   input  logic [REF_W-1:0]       tref,
   output logic                   syn_req,
   output logic [IDX_W-1:0]       syn_idx,
   input  logic                   syn_valid,
   input  logic [SYN_N-1:0]       spike_in,
   input  logic [SYN_N*POT_W-1:0] weight,
   output logic                   out_valid,
   output logic [IDX_W-1:0]       out_idx,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   step_done,
   input  logic [IDX_W-1:0]       dbg_idx,
   output logic [POT_W-1:0]       dbg_potential,
   output logic [REF_W-1:0]       dbg_refrac,
   output logic [2:0]             dbg_state
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   lif_state_e             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [POT_W-1:0]       thr_q, leak_q;
   logic [REF_W-1:0]       tref_q;
   logic [SYN_N-1:0]       spk_q;
   logic [SYN_N*POT_W-1:0] wgt_q;
   logic                   cfg_load, syn_load;

   logic                   syn_req_q, out_valid_q, busy_q, step_done_q;
   logic [IDX_W-1:0]       syn_idx_q, out_idx_q;

   logic [POT_W-1:0]       pot_q [NUM_NEURONS];
   logic [REF_W-1:0]       ref_q [NUM_NEURONS];

   logic [POT_W-1:0]       upd_pot;
   logic [REF_W-1:0]       upd_ref;
   logic                   upd_fire;

   lif_update_unit u_update (
      .potential      (pot_q[idx_q]),
      .refrac         (ref_q[idx_q]),
      .spike_in       (spk_q),
      .weight         (wgt_q),
      .threshold      (thr_q),
      .leak_value     (leak_q),
      .tref           (tref_q),
      .potential_next (upd_pot),
      .refrac_next    (upd_ref),
      .fire           (upd_fire)
   );

   // Next-state logic. "Advance" (after a non-firing update or an accepted
   // event) moves to the next neuron or finishes the step after the last one.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cfg_load = 1'b0;
      syn_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (step_start) begin
               state_d  = FETCH;
               idx_d    = '0;
               cfg_load = 1'b1;
            end
         end
         FETCH: begin
            if (syn_req_q && syn_valid) begin
               state_d  = UPDATE;
               syn_load = 1'b1;
            end
         end
         UPDATE: begin
            if (upd_fire) begin
               state_d = EMIT;
            end else if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               state_d = FETCH;
               idx_d   = idx_q + 1'b1;
            end
         end
         EMIT: begin
            if (out_valid_q && out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  state_d = FETCH;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers; outputs are registered from the next state so they
   // line up with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         thr_q       <= '0;
         leak_q      <= '0;
         tref_q      <= '0;
         spk_q       <= '0;
         wgt_q       <= '0;
         syn_req_q   <= 1'b0;
         syn_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         busy_q      <= 1'b0;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         if (cfg_load) begin
            thr_q  <= threshold;
            leak_q <= leak_value;
            tref_q <= tref;
         end
         if (syn_load) begin
            spk_q <= spike_in;
            wgt_q <= weight;
         end
         syn_req_q   <= (state_d == FETCH);
         syn_idx_q   <= idx_d;
         out_valid_q <= (state_d == EMIT);
         out_idx_q   <= idx_d;
         busy_q      <= (state_d != IDLE);
         step_done_q <= (state_d == DONE);
      end
   end

   // Neuron state file; written back on the UPDATE edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            pot_q[n] <= '0;
            ref_q[n] <= '0;
         end
      end else if (state_q == UPDATE) begin
         pot_q[idx_q] <= upd_pot;
         ref_q[idx_q] <= upd_ref;
      end
   end

   assign syn_req       = syn_req_q;
   assign syn_idx       = syn_idx_q;
   assign out_valid     = out_valid_q;
   assign out_idx       = out_idx_q;
   assign busy          = busy_q;
   assign step_done     = step_done_q;
   assign dbg_potential = pot_q[dbg_idx];
   assign dbg_refrac    = ref_q[dbg_idx];
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
module tb_lif_neuron_scheduler;

   localparam int N  = 4;
   localparam int IW = 2;

   // ---------------- clock / reset / DUT ----------------
   logic          clk;
   logic          reset_n;
   logic          step_start;
   logic [7:0]    threshold, leak_value;
   logic [3:0]    tref;
   logic          syn_req;
   logic [IW-1:0] syn_idx;
   logic          syn_valid;
   logic [7:0]    spike_in;
   logic [63:0]   weight;
   logic          out_valid;
   logic [IW-1:0] out_idx;
   logic          out_ready;
   logic          busy, step_done;
   logic [IW-1:0] dbg_idx;
   logic [7:0]    dbg_potential;
   logic [3:0]    dbg_refrac;
   logic [2:0]    dbg_state;

   logic [7:0]    spk_tab [N];
   logic [63:0]   wgt_tab [N];

   int            checks;
   int            failures;
   logic [IW-1:0] exp_q [$];
   logic [IW-1:0] got_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream memory model: data follows the requested index.
   assign spike_in = spk_tab[syn_idx];
   assign weight   = wgt_tab[syn_idx];

   lif_neuron_scheduler #(.NUM_NEURONS(N)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .step_start    (step_start),
      .threshold     (threshold),
      .leak_value    (leak_value),
      .tref          (tref),
      .syn_req       (syn_req),
      .syn_idx       (syn_idx),
      .syn_valid     (syn_valid),
      .spike_in      (spike_in),
      .weight        (weight),
      .out_valid     (out_valid),
      .out_idx       (out_idx),
      .out_ready     (out_ready),
      .busy          (busy),
      .step_done     (step_done),
      .dbg_idx       (dbg_idx),
      .dbg_potential (dbg_potential),
      .dbg_refrac    (dbg_refrac),
      .dbg_state     (dbg_state)
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_neuron(input int i, input logic [7:0] pot_e, input logic [3:0] ref_e);
      dbg_idx = IW'(i);
      #1;
      chk($sformatf("potential[%0d]", i), dbg_potential, pot_e);
      chk($sformatf("refrac[%0d]", i), dbg_refrac, ref_e);
   endtask

   task automatic set_tabs(input logic [7:0] spk, input logic [63:0] wgt);
      for (int i = 0; i < N; i++) begin
         spk_tab[i] = spk;
         wgt_tab[i] = wgt;
      end
   endtask

   // ---------------- driver ----------------
   // Runs one timestep. step_done is expected in cycle exp_cycles, counting
   // the step_start cycle as cycle 1. Optional: hold off syn_valid for
   // delay_len cycles on neuron delay_idx, hold out_ready low for bp_len
   // cycles on neuron bp_idx, pulse step_start again at cycle extra_start,
   // and assert step_start in the step_done cycle.
   task automatic run_step(input int delay_idx, input int delay_len,
                           input int bp_idx, input int bp_len,
                           input int extra_start, input bit start_at_done,
                           input int exp_cycles);
      int cyc;
      int dly;
      int bp;
      int exp_fetch;
      bit done;
      cyc = 0; dly = 0; bp = 0; exp_fetch = 0; done = 0;
      got_q.delete();
      @(negedge clk);
      step_start = 1'b1;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         step_start = (cyc == extra_start);
         syn_valid  = 1'b0;
         out_ready  = 1'b1;
         if (syn_req) begin
            if (int'(syn_idx) == delay_idx && dly < delay_len) begin
               chk("stall_syn_idx", syn_idx, exp_fetch);
               dly++;
            end else begin
               chk("fetch_order", syn_idx, exp_fetch);
               syn_valid = 1'b1;
               exp_fetch++;
            end
         end
         if (out_valid) begin
            if (int'(out_idx) == bp_idx && bp < bp_len) begin
               out_ready = 1'b0;
               bp++;
               chk("bp_out_idx", out_idx, bp_idx);
               chk("bp_no_syn_req", syn_req, 0);
            end else begin
               got_q.push_back(out_idx);
            end
         end
         if (step_done) begin
            done = 1;
            chk("step_cycles", cyc, exp_cycles);
            if (start_at_done) step_start = 1'b1;
         end
      end
      if (!done) chk("step_timeout", 0, 1);
      @(negedge clk);
      step_start = 1'b0;
      syn_valid  = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_syn_req", syn_req, 0);
      chk("fetch_count", exp_fetch, N);
      chk("spike_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("spike_idx[%0d]", i), got_q[i], exp_q[i]);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bit seen_done;
      checks = 0; failures = 0;
      reset_n = 1'b0; step_start = 1'b0; syn_valid = 1'b0; out_ready = 1'b1;
      threshold = 8'd0; leak_value = 8'd0; tref = 4'd0; dbg_idx = '0;
      set_tabs(8'h00, 64'h0);

      repeat (3) @(negedge clk);
      chk("rst_syn_req", syn_req, 0);
      chk("rst_syn_idx", syn_idx, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_step_done", step_done, 0);
      chk("rst_state", dbg_state, 0);
      for (int i = 0; i < N; i++) check_neuron(i, 8'd0, 4'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Step 1: 0 + 30 + 30 - 2 = 58 < 100, no spikes, 9 cycles.
      threshold = 8'd100; leak_value = 8'd2; tref = 4'd2;
      set_tabs(8'h03, {8{8'd30}});
      exp_q.delete();
      run_step(-1, 0, -1, 0, 0, 0, 9);
      for (int i = 0; i < N; i++) check_neuron(i, 8'd58, 4'd0);

      // Step 2: 58 + 60 = 118, 116 >= 100, all fire; neuron 1 back-pressured 5 cycles.
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      run_step(-1, 0, 1, 5, 0, 0, 18);
      for (int i = 0; i < N; i++) check_neuron(i, 8'd0, 4'd2);

      // Step 3: refractory 2 -> 1; neuron 2 fetch delayed 3; stray step_start ignored.
      exp_q.delete();
      run_step(2, 3, -1, 0, 4, 0, 12);
      for (int i = 0; i < N; i++) check_neuron(i, 8'd0, 4'd1);

      // Step 4: refractory 1 -> 0; step_start in the step_done cycle ignored.
      run_step(-1, 0, -1, 0, 0, 1, 9);
      for (int i = 0; i < N; i++) check_neuron(i, 8'd0, 4'd0);

      // Step 5: firing resumes: 0 + 120 - 2 = 118 >= 100.
      set_tabs(8'h03, {8{8'd60}});
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      run_step(-1, 0, -1, 0, 0, 0, 13);
      for (int i = 0; i < N; i++) check_neuron(i, 8'd0, 4'd2);

      // Reset in the middle of a step.
      set_tabs(8'h03, {8{8'd30}});
      @(negedge clk);
      step_start = 1'b1;
      syn_valid  = 1'b1;
      @(negedge clk);
      step_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_step_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("arst_syn_req", syn_req, 0);
      chk("arst_syn_idx", syn_idx, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_idx", out_idx, 0);
      chk("arst_busy", busy, 0);
      chk("arst_step_done", step_done, 0);
      chk("arst_state", dbg_state, 0);
      for (int i = 0; i < N; i++) check_neuron(i, 8'd0, 4'd0);
      @(negedge clk);
      reset_n   = 1'b1;
      syn_valid = 1'b0;
      seen_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (step_done || busy) seen_done = 1;
      end
      chk("no_done_after_reset", seen_done, 0);

      // Saturation, step A: neuron 0 builds potential 250.
      threshold = 8'd255; leak_value = 8'd0; tref = 4'd0;
      set_tabs(8'h00, 64'h0);
      spk_tab[0] = 8'h01;
      wgt_tab[0] = 64'h0000_0000_0000_00FA;
      exp_q.delete();
      run_step(-1, 0, -1, 0, 0, 0, 9);
      check_neuron(0, 8'd250, 4'd0);
      check_neuron(1, 8'd0, 4'd0);

      // Step B: 250 + 8*255 saturates to 255 >= 255, neuron 0 fires, tref 0.
      spk_tab[0] = 8'hFF;
      wgt_tab[0] = {8{8'hFF}};
      exp_q = '{2'd0};
      run_step(-1, 0, -1, 0, 0, 0, 10);
      check_neuron(0, 8'd0, 4'd0);

      // Step C: threshold 0 with sum 0 >= leak 0: every neuron fires.
      threshold = 8'd0; tref = 4'd3;
      set_tabs(8'h00, 64'h0);
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      run_step(-1, 0, -1, 0, 0, 0, 13);
      for (int i = 0; i < N; i++) check_neuron(i, 8'd0, 4'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
